// File: rtl/board_controller_pkg.sv
// Shared definitions for the tic-tac-toe board controller: cell codes, FSM
// states and board geometry.
package board_controller_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    O     = 2'b01,
    X     = 2'b10
  } cell_t;

  typedef enum logic [1:0] {
    TURN_X = 2'b00,
    TURN_O = 2'b01,
    CHECK  = 2'b10,
    OVER   = 2'b11
  } state_t;

  localparam int NUM_CELLS = 9;

  localparam logic [3:0] TOP_LEFT      = 4'd0;
  localparam logic [3:0] TOP_CENTER    = 4'd1;
  localparam logic [3:0] TOP_RIGHT     = 4'd2;
  localparam logic [3:0] MIDDLE_LEFT   = 4'd3;
  localparam logic [3:0] MIDDLE_CENTER = 4'd4;
  localparam logic [3:0] MIDDLE_RIGHT  = 4'd5;
  localparam logic [3:0] BOTTON_LEFT   = 4'd6;
  localparam logic [3:0] BOTTON_CENTER = 4'd7;
  localparam logic [3:0] BOTTON_RIGHT  = 4'd8;

  // Maps a player's cell code to the FSM state in which that player moves.
  function automatic state_t turn_of(input logic [1:0] player);
    return (player == O) ? TURN_O : TURN_X;
  endfunction

endpackage

// File: rtl/board_controller.sv
// Tic-tac-toe board controller: accepts moves, keeps the 3x3 board, and
// resolves win/draw from an external combinational win checker.
module board_controller
  import board_controller_pkg::*;
#(
  parameter logic [1:0] FIRST_PLAYER = 2'b10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       newGame,
  input  logic       moveValid,
  input  logic [3:0] moveCell,
  output logic       moveReady,
  input  logic       Xwins,
  input  logic       Owins,
  output logic [1:0] topLeft,
  output logic [1:0] topCenter,
  output logic [1:0] topRight,
  output logic [1:0] middleLeft,
  output logic [1:0] middleCenter,
  output logic [1:0] middleRight,
  output logic [1:0] bottonLeft,
  output logic [1:0] bottonCenter,
  output logic [1:0] bottonRight,
  output logic [1:0] currentPlayer,
  output logic       moveAccepted,
  output logic       moveRejected,
  output logic [3:0] moveCount,
  output logic       gameOver,
  output logic [1:0] winner
);

  localparam state_t FIRST_STATE = turn_of(FIRST_PLAYER);

  state_t     state, state_nxt;
  logic [1:0] cells [NUM_CELLS];
  logic [1:0] mover, mover_nxt;
  logic [1:0] winner_nxt;
  logic [1:0] player;
  logic       target_free;
  logic       handshake;
  logic       accept, reject, write_en, clear;

  assign handshake = moveValid && moveReady;
  assign gameOver  = (state == OVER);
  assign moveReady = ((state == TURN_X) || (state == TURN_O)) && !newGame;

  always_comb begin
    player = (state == TURN_O) ? O : X;
    target_free = 1'b0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if ((moveCell == i[3:0]) && (cells[i] == EMPTY)) target_free = 1'b1;
    end
  end

  always_comb begin
    unique case (state)
      TURN_X:  currentPlayer = X;
      TURN_O:  currentPlayer = O;
      CHECK:   currentPlayer = mover;
      default: currentPlayer = EMPTY;
    endcase
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_nxt  = state;
    mover_nxt  = mover;
    winner_nxt = winner;
    accept     = 1'b0;
    reject     = 1'b0;
    write_en   = 1'b0;
    clear      = 1'b0;
    if (newGame) begin
      clear      = 1'b1;
      winner_nxt = EMPTY;
      state_nxt  = FIRST_STATE;
    end else begin
      unique case (state)
        TURN_X, TURN_O: begin
          if (handshake) begin
            if (target_free) begin
              write_en  = 1'b1;
              accept    = 1'b1;
              mover_nxt = player;
              state_nxt = CHECK;
            end else begin
              reject = 1'b1;
            end
          end
        end
        CHECK: begin
          if (Xwins) begin
            winner_nxt = X;
            state_nxt  = OVER;
          end else if (Owins) begin
            winner_nxt = O;
            state_nxt  = OVER;
          end else if (moveCount == 4'(NUM_CELLS)) begin
            winner_nxt = EMPTY;
            state_nxt  = OVER;
          end else begin
            state_nxt = (mover == X) ? TURN_O : TURN_X;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the board is only nine 2-bit registers, so it is reset like any
  // other state; a large RAM would instead be cleared by a sequencer.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CELLS; i++) cells[i] <= EMPTY;
      moveCount    <= '0;
      winner       <= EMPTY;
      mover        <= FIRST_PLAYER;
      state        <= FIRST_STATE;
      moveAccepted <= 1'b0;
      moveRejected <= 1'b0;
    end else begin
      state        <= state_nxt;
      mover        <= mover_nxt;
      winner       <= winner_nxt;
      moveAccepted <= accept;
      moveRejected <= reject;
      if (clear) begin
        for (int i = 0; i < NUM_CELLS; i++) cells[i] <= EMPTY;
        moveCount <= '0;
      end else if (write_en) begin
        for (int i = 0; i < NUM_CELLS; i++) begin
          if (moveCell == i[3:0]) cells[i] <= player;
        end
        if (moveCount < 4'(NUM_CELLS)) moveCount <= moveCount + 4'd1;
      end
    end
  end

  assign topLeft      = cells[TOP_LEFT];
  assign topCenter    = cells[TOP_CENTER];
  assign topRight     = cells[TOP_RIGHT];
  assign middleLeft   = cells[MIDDLE_LEFT];
  assign middleCenter = cells[MIDDLE_CENTER];
  assign middleRight  = cells[MIDDLE_RIGHT];
  assign bottonLeft   = cells[BOTTON_LEFT];
  assign bottonCenter = cells[BOTTON_CENTER];
  assign bottonRight  = cells[BOTTON_RIGHT];

endmodule

// File: tb/tb_board_controller.sv
// Self-checking bench: directed game scenarios plus random play, compared each
// cycle against a move-level reference model of the game rules.
module tb_board_controller;

  localparam logic [1:0] FIRST = 2'b10;
  localparam int FIRST_CODE = 2;
  // Bit i of each 9-bit mask selects cell i; rows, columns, diagonals.
  localparam logic [71:0] LINE_MASKS = {
    9'b000000111, 9'b000111000, 9'b111000000,
    9'b001001001, 9'b010010010, 9'b100100100,
    9'b100010001, 9'b001010100
  };

  logic       clk = 1'b0;
  logic       rst, newGame, moveValid;
  logic [3:0] moveCell;
  logic       moveReady, Xwins, Owins;
  logic [1:0] topLeft, topCenter, topRight, middleLeft, middleCenter, middleRight;
  logic [1:0] bottonLeft, bottonCenter, bottonRight, currentPlayer, winner;
  logic       moveAccepted, moveRejected, gameOver;
  logic [3:0] moveCount;
  logic [17:0] dut_board;
  logic       x_noise = 1'b0, o_noise = 1'b0;

  int errors = 0;
  int checks = 0;

  // Reference model of the game.
  int b [9];
  int cnt, win, turn;
  bit checking, over, exp_acc, exp_rej;
  int acc_seen, rej_seen;

  board_controller #(.FIRST_PLAYER(FIRST)) dut (
    .clk(clk), .rst(rst), .newGame(newGame), .moveValid(moveValid),
    .moveCell(moveCell), .moveReady(moveReady), .Xwins(Xwins), .Owins(Owins),
    .topLeft(topLeft), .topCenter(topCenter), .topRight(topRight),
    .middleLeft(middleLeft), .middleCenter(middleCenter), .middleRight(middleRight),
    .bottonLeft(bottonLeft), .bottonCenter(bottonCenter), .bottonRight(bottonRight),
    .currentPlayer(currentPlayer), .moveAccepted(moveAccepted),
    .moveRejected(moveRejected), .moveCount(moveCount), .gameOver(gameOver),
    .winner(winner)
  );

  always #5 clk = ~clk;

  function automatic logic line_win(input logic [17:0] board, input logic [1:0] p);
    logic [8:0] m;
    logic [8:0] line;
    logic       hit;
    hit = 1'b0;
    for (int i = 0; i < 9; i++) m[i] = (board[2*i +: 2] == p);
    for (int l = 0; l < 8; l++) begin
      line = LINE_MASKS[9*l +: 9];
      if ((m & line) == line) hit = 1'b1;
    end
    return hit;
  endfunction

  // External win checker, fed from the controller's cell outputs.
  assign dut_board = {bottonRight, bottonCenter, bottonLeft, middleRight, middleCenter,
                      middleLeft, topRight, topCenter, topLeft};
  assign Xwins = line_win(dut_board, 2'b10) | x_noise;
  assign Owins = line_win(dut_board, 2'b01) | o_noise;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [17:0] model_board();
    logic [17:0] r;
    for (int i = 0; i < 9; i++) r[2*i +: 2] = 2'(b[i]);
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 9; i++) b[i] = 0;
    cnt = 0; win = 0; turn = FIRST_CODE;
    checking = 0; over = 0; exp_acc = 0; exp_rej = 0;
  endtask

  task automatic model_step(input bit ng, input bit mv, input int mc, input bit xw, input bit ow);
    exp_acc = 0;
    exp_rej = 0;
    if (ng) begin
      model_clear();
    end else if (over) begin
      // game finished: everything ignored
    end else if (checking) begin
      checking = 0;
      if (xw) begin over = 1; win = 2; end
      else if (ow) begin over = 1; win = 1; end
      else if (cnt == 9) begin over = 1; win = 0; end
      else turn = 3 - turn;
    end else if (mv) begin
      if (mc < 9 && b[mc] == 0) begin
        b[mc] = turn;
        cnt++;
        exp_acc = 1;
        checking = 1;
      end else begin
        exp_rej = 1;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".cells"}, 32'(dut_board), 32'(model_board()));
    check({tag, ".count"}, 32'(moveCount), 32'(cnt));
    check({tag, ".acc"}, 32'(moveAccepted), 32'(exp_acc));
    check({tag, ".rej"}, 32'(moveRejected), 32'(exp_rej));
    check({tag, ".over"}, 32'(gameOver), 32'(over));
    check({tag, ".winner"}, 32'(winner), 32'(win));
    if (!checking) check({tag, ".player"}, 32'(currentPlayer), over ? 32'd0 : 32'(turn));
  endtask

  // One clock cycle: drive inputs, check moveReady, advance model and DUT.
  task automatic step(input string tag, input bit ng, input bit mv, input int mc);
    bit xw, ow;
    newGame   = ng;
    moveValid = mv;
    moveCell  = mc[3:0];
    x_noise   = !checking && ($urandom_range(0, 3) == 0);
    o_noise   = !checking && ($urandom_range(0, 3) == 0);
    #1;
    check({tag, ".ready"}, 32'(moveReady), 32'(!over && !checking && !ng));
    xw = line_win(model_board(), 2'b10) | x_noise;
    ow = line_win(model_board(), 2'b01) | o_noise;
    model_step(ng, mv, mc, xw, ow);
    @(posedge clk);
    #1;
    if (moveAccepted) acc_seen++;
    if (moveRejected) rej_seen++;
    compare_all(tag);
  endtask

  // A move offer followed by its CHECK cycle, with a stray offer during CHECK.
  task automatic play(input string tag, input int mc);
    step(tag, 1'b0, 1'b1, mc);
    step({tag, "_chk"}, 1'b0, 1'b1, $urandom_range(0, 8));
  endtask

  int draw_seq [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
  int win_seq  [5] = '{0, 3, 1, 4, 2};

  initial begin
    rst = 1'b1; newGame = 1'b0; moveValid = 1'b0; moveCell = '0;
    model_clear();
    #12;
    compare_all("reset");
    check("reset.ready", 32'(moveReady), 32'd1);
    check("reset.player", 32'(currentPlayer), 32'(FIRST));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // X wins along the top row.
    acc_seen = 0;
    foreach (win_seq[i]) play("win", win_seq[i]);
    check("win.accepts", 32'(acc_seen), 32'd5);
    check("win.gameover", 32'(gameOver), 32'd1);
    check("win.winner", 32'(winner), 32'd2);
    check("win.player", 32'(currentPlayer), 32'd0);
    check("win.ready", 32'(moveReady), 32'd0);

    // Offers while OVER are ignored, regardless of win-flag noise.
    acc_seen = 0; rej_seen = 0;
    for (int i = 0; i < 4; i++) step("over_move", 1'b0, 1'b1, 5 + i);
    check("over.pulses", 32'(acc_seen + rej_seen), 32'd0);

    // Draw.
    step("ng1", 1'b1, 1'b0, 0);
    foreach (draw_seq[i]) play("draw", draw_seq[i]);
    check("draw.count", 32'(moveCount), 32'd9);
    check("draw.gameover", 32'(gameOver), 32'd1);
    check("draw.winner", 32'(winner), 32'd0);

    // Rejections: occupied cell, then out-of-range cell.
    step("ng2", 1'b1, 1'b0, 0);
    play("rej_first", 4);
    rej_seen = 0;
    step("rej_occupied", 1'b0, 1'b1, 4);
    step("rej_range", 1'b0, 1'b1, 12);
    check("rej.pulses", 32'(rej_seen), 32'd2);
    check("rej.count", 32'(moveCount), 32'd1);
    check("rej.player", 32'(currentPlayer), 32'd1);
    check("rej.center", 32'(middleCenter), 32'd2);

    // newGame beats a simultaneous legal move.
    play("mid", 0);
    step("ng_move", 1'b1, 1'b1, 8);
    check("ng_move.count", 32'(moveCount), 32'd0);
    check("ng_move.acc", 32'(moveAccepted), 32'd0);
    check("ng_move.player", 32'(currentPlayer), 32'(FIRST));

    // Asynchronous reset in the middle of a CHECK cycle.
    play("pre_rst", 2);
    step("rst_acc", 1'b0, 1'b1, 6);
    newGame = 1'b0; moveValid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_clear();
    compare_all("rst_async");
    check("rst_async.ready", 32'(moveReady), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    acc_seen = 0; rej_seen = 0;
    for (int i = 0; i < 3; i++) step("post_rst", 1'b0, 1'b0, 0);
    check("post_rst.pulses", 32'(acc_seen + rej_seen), 32'd0);

    // Random play.
    for (int i = 0; i < 2000; i++) begin
      step("rand", ($urandom_range(0, 39) == 0), $urandom_range(0, 1) == 1,
           $urandom_range(0, 11));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
